seq_det_ctrl: RTL
=================

# seq_det_ctrl

Programmable serial-pattern detection controller. Accepts a pattern, length, overlap mode and match target over a ready/valid config port, then arms a windowed matcher on the serial input stream. It counts matches and stops once the target is reached. It is the configurable, sequenced replacement for the fixed-pattern Moore detectors and sits between the serial bit source and the match consumer/status logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- CNT_W, 8: width of match counter and target.
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len (derived, not overridden).
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  high in IDLE and DONE only.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length; valid range is 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- cfg_target  in  CNT_W  matches before DONE; 0 = unlimited.
- start  in  1  arm request (IDLE/DONE only).
- stop  in  1  abort to IDLE (ARMED only).
- in_valid  in  1  qualifies `in`.
- in  in  1  serial data bit.
- match  out  1  registered one-cycle pulse per detected match.
- match_count  out  CNT_W  matches since last start.
- busy  out  1  state == ARMED.
- done  out  1  state == DONE.
- cfg_err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, ARMED, DONE.
- Reset values: state IDLE; config registers 0 (so len = 0, invalid); history 0; fill 0; match, match_count, done, busy and cfg_err all 0.
- Config:
  - Accepted on cfg_valid && cfg_ready; the shadow registers are updated at that edge.
  - Config offered in ARMED is not accepted (cfg_ready = 0) and has no effect.
- Start:
  - In IDLE or DONE, start goes to ARMED and clears history, fill, match_count and done.
  - If cfg_valid && cfg_ready occurs in the same cycle as start, start uses the incoming config values.
  - If the effective len is 0 or > MAX_LEN, start is rejected: cfg_err pulses the next cycle and the state is unchanged.
- Matching in ARMED, for each in_valid bit:
  - history <= {history[MAX_LEN-2:0], in}.
  - fill increments, saturating at MAX_LEN.
  - Match when the new fill >= len and the low len bits of the new history equal cfg_pattern[len-1:0].
  - On a match, match_count increments.
  - Non-overlap mode: on a match, fill is cleared to 0 (history contents are kept but masked by fill).
  - in_valid = 0 cycles: no shift and no state change.
- Target:
  - If target != 0 and the incremented count == target, go to DONE on the same edge.
  - In DONE, in/in_valid are ignored and count is held.
- Stop: in ARMED, stop goes to IDLE and holds count. If stop arrives with a matching bit in the same cycle, the match is counted and pulsed, then the state goes to IDLE.
- stop in IDLE or DONE is ignored.
- start in ARMED is ignored.
- Count wrap: with target 0, match_count wraps modulo 2^CNT_W.

## Timing
- match is asserted in the cycle after the edge that samples the completing bit (Moore-style, 1-cycle latency). match_count and done update on that same edge.
- cfg_ready, busy and done are decoded from registered state; there is no combinational path from inputs to these outputs.
- ARMED is entered one edge after an accepted start. The first in_valid bit is sampled on the following edge.
- Back-to-back matches (pattern of all 1s, overlap mode) produce a match every valid cycle.
- rst at any point, including mid-ARMED, returns all outputs and config to their reset values on the next edge.

## Structure
- Package seq_det_pkg holds:
  - the state enum (IDLE/ARMED/DONE);
  - default MAX_LEN and CNT_W constants;
  - a config struct {pattern, len, overlap, target}.
- Sub-module seq_window_match holds the history shift register, fill counter and masked compare. Its interface:
  - inputs: shift, clear, fill_clr, pattern, len;
  - output: hit, combinational on the next-state window.
- The top level holds the FSM, config shadow, counter and output registers.

## Test plan
- Overlap detection: pattern 10011, len 5, overlap 1, target 0; stream 1,0,0,1,1,0,0,1,1 -> match after bit 5 and bit 9, count = 2.
- Non-overlap detection: same stream with overlap 0 -> match after bit 5 only, count = 1.
- Target stop: pattern 11, len 2, overlap 1, target 2; stream 1,1,1,1 -> matches after bits 2 and 3, done = 1, bit 4 ignored, count stays 2, cfg_ready = 1.
- Invalid length: len 0 loaded, then start -> cfg_err single pulse, busy stays 0. Then load len 9 with start in the same cycle -> rejected, cfg_err pulse.
- Gaps and stop: pattern 101 with in_valid deasserted between bits -> match still after the third valid bit. stop asserted mid-pattern -> IDLE, count held.
- Reset mid-operation: rst during ARMED after 1 match -> next cycle count = 0, busy = 0, cfg_ready = 1, and start is rejected (config cleared).

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial-pattern detector.
package seq_det_pkg;

  localparam int unsigned SEQ_MAX_LEN = 8;
  localparam int unsigned SEQ_CNT_W   = 8;
  localparam int unsigned SEQ_LEN_W   = $clog2(SEQ_MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEQ_MAX_LEN-1:0] pattern;
    logic [SEQ_LEN_W-1:0]   len;
    logic                   overlap;
    logic [SEQ_CNT_W-1:0]   target;
  } seq_cfg_t;

  // A length is usable only inside 1..SEQ_MAX_LEN.
  function automatic logic len_valid(input logic [SEQ_LEN_W-1:0] len);
    return (len != '0) && (32'(len) <= SEQ_MAX_LEN);
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// History shift register, fill counter and masked pattern compare.
// hit reflects the window as it will be after the current shift.
module seq_window_match
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = SEQ_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               clear,
  input  logic               fill_clr,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic [MAX_LEN-1:0] w_mask;

  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], din};
  assign w_fill_nxt = (32'(r_fill) >= MAX_LEN) ? LEN_W'(MAX_LEN) : r_fill + LEN_W'(1);

  // Only the low len bits take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (i < int'(len)) w_mask[i] = 1'b1;
    end
  end

  assign hit = shift && (len != '0) && (w_fill_nxt >= len) &&
               (((w_hist_nxt ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_hist <= w_hist_nxt;
      r_fill <= fill_clr ? '0 : w_fill_nxt;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequencing controller: config shadow, IDLE/ARMED/DONE FSM, match counter
// and registered status outputs around the windowed matcher.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = SEQ_MAX_LEN,
  parameter int unsigned CNT_W   = SEQ_CNT_W,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_t           r_state, w_state_nxt;
  seq_cfg_t         r_cfg, w_cfg_nxt, w_cfg_in, w_cfg_eff;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_match, w_match_nxt;
  logic             r_err, w_err_nxt;
  logic             r_busy, r_done, r_cfg_ready;
  logic             w_cfg_acc, w_clear, w_shift, w_fill_clr, w_hit;

  assign w_cfg_acc  = cfg_valid && r_cfg_ready;
  assign w_shift    = (r_state == ST_ARMED) && in_valid;
  assign w_fill_clr = w_hit && !r_cfg.overlap;

  always_comb begin
    w_cfg_in.pattern = SEQ_MAX_LEN'(cfg_pattern);
    w_cfg_in.len     = SEQ_LEN_W'(cfg_len);
    w_cfg_in.overlap = cfg_overlap;
    w_cfg_in.target  = SEQ_CNT_W'(cfg_target);
  end

  // A start in the same cycle as an accepted config sees the new values.
  assign w_cfg_eff = w_cfg_acc ? w_cfg_in : r_cfg;

  seq_window_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift    (w_shift),
    .clear    (w_clear),
    .fill_clr (w_fill_clr),
    .din      (in),
    .pattern  (MAX_LEN'(r_cfg.pattern)),
    .len      (LEN_W'(r_cfg.len)),
    .hit      (w_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_nxt   = r_cfg;
    w_count_nxt = r_count;
    w_match_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_clear     = 1'b0;

    if (w_cfg_acc) w_cfg_nxt = w_cfg_in;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (len_valid(w_cfg_eff.len)) begin
            w_state_nxt = ST_ARMED;
            w_clear     = 1'b1;
            w_count_nxt = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (w_hit) begin
          w_count_nxt = r_count + CNT_W'(1);
          w_match_nxt = 1'b1;
          if ((r_cfg.target != '0) && (w_count_nxt == CNT_W'(r_cfg.target)))
            w_state_nxt = ST_DONE;
        end
        // A stop still lets a same-cycle match be counted first.
        if (stop) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cfg       <= '0;
      r_count     <= '0;
      r_match     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg       <= w_cfg_nxt;
      r_count     <= w_count_nxt;
      r_match     <= w_match_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= (w_state_nxt == ST_ARMED);
      r_done      <= (w_state_nxt == ST_DONE);
      r_cfg_ready <= (w_state_nxt != ST_ARMED);
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign match       = r_match;
  assign match_count = r_count;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_err     = r_err;

endmodule
